// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04 style sensor model: answers a validated trig pulse with an echo whose width encodes dist_cm.
// Optional measurement noise: define ECHO_JITTER_EN to add an 8-bit LFSR value to every echo width.
module ultrasonic_echo_responder #(
  parameter int unsigned TRIG_MIN_CYC    = 500,
  parameter int unsigned BURST_DELAY_CYC = 25000,
  parameter int unsigned CYC_PER_CM      = 2900,
  parameter int unsigned MAX_CM          = 400,
  parameter int unsigned MAX_ECHO_CYC    = 1900000,
  parameter int unsigned HOLDOFF_CYC     = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [8:0] dist_cm,
  output logic       echo,
  output logic       busy,
  output logic       meas_done,
  output logic       err_short
);

  localparam int CW = 21;
  localparam int TW = $clog2(TRIG_MIN_CYC + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG_HI = 3'd1,
    BURST   = 3'd2,
    ECHO    = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  state_t          state, next_state;
  logic            trig_meta, trig_s, trig_prev;
  logic [TW-1:0]   wcnt, wcnt_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [CW-1:0]   width, width_nxt;
  logic            meas_done_nxt, err_short_nxt;
  logic            accept;
  logic [7:0]      jitter;

  function automatic logic [CW-1:0] echo_width(input logic [8:0] d, input logic [7:0] j);
    logic [CW-1:0] base;
    if (d == 9'd0 || d > 9'(MAX_CM)) begin
      base = CW'(MAX_ECHO_CYC);
    end else begin
      base = CW'(d) * CW'(CYC_PER_CM);
    end
    return base + CW'(j);
  endfunction

`ifdef ECHO_JITTER_EN
  logic [7:0] lfsr;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 8'hA5;
    end else if (accept) begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  assign jitter = lfsr;
`else
  assign jitter = 8'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_meta <= 1'b0;
      trig_s    <= 1'b0;
      trig_prev <= 1'b0;
    end else begin
      trig_meta <= trig;
      trig_s    <= trig_meta;
      trig_prev <= trig_s;
    end
  end

  always_comb begin
    next_state    = state;
    wcnt_nxt      = wcnt;
    cnt_nxt       = cnt;
    width_nxt     = width;
    meas_done_nxt = 1'b0;
    err_short_nxt = 1'b0;
    accept        = 1'b0;
    case (state)
      IDLE: begin
        if (trig_s && !trig_prev) begin
          wcnt_nxt   = '0;
          next_state = TRIG_HI;
        end
      end
      TRIG_HI: begin
        // Width counter saturates so a stuck-high trigger cannot wrap back to "short"
        if (trig_s) begin
          if (wcnt < TW'(TRIG_MIN_CYC)) begin
            wcnt_nxt = wcnt + TW'(1);
          end
        end else if (wcnt >= TW'(TRIG_MIN_CYC)) begin
          accept     = 1'b1;
          width_nxt  = echo_width(dist_cm, jitter);
          cnt_nxt    = '0;
          next_state = BURST;
        end else begin
          err_short_nxt = 1'b1;
          next_state    = IDLE;
        end
      end
      BURST: begin
        if (cnt == CW'(BURST_DELAY_CYC)) begin
          cnt_nxt    = '0;
          next_state = ECHO;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ECHO: begin
        if (cnt == width - CW'(1)) begin
          cnt_nxt       = '0;
          meas_done_nxt = 1'b1;
          next_state    = HOLDOFF;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HOLDOFF: begin
        if (cnt == CW'(HOLDOFF_CYC - 1)) begin
          cnt_nxt    = '0;
          next_state = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so echo lines up exactly with the ECHO state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wcnt      <= '0;
      cnt       <= '0;
      width     <= '0;
      echo      <= 1'b0;
      busy      <= 1'b0;
      meas_done <= 1'b0;
      err_short <= 1'b0;
    end else begin
      state     <= next_state;
      wcnt      <= wcnt_nxt;
      cnt       <= cnt_nxt;
      width     <= width_nxt;
      echo      <= (next_state == ECHO);
      busy      <= (next_state != IDLE);
      meas_done <= meas_done_nxt;
      err_short <= err_short_nxt;
    end
  end

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Scoreboard bench for ultrasonic_echo_responder with scaled-down timing parameters.
module tb_ultrasonic_echo_responder;

  localparam int TMIN = 8;
  localparam int BD   = 20;
  localparam int CPC  = 29;
  localparam int MAXC = 40;
  localparam int MAXE = 1900;
  localparam int HO   = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic [8:0] dist_cm = 9'd0;
  logic       echo, busy, meas_done, err_short;

  ultrasonic_echo_responder #(
    .TRIG_MIN_CYC(TMIN), .BURST_DELAY_CYC(BD), .CYC_PER_CM(CPC),
    .MAX_CM(MAXC), .MAX_ECHO_CYC(MAXE), .HOLDOFF_CYC(HO)
  ) dut (
    .clk(clk), .rst(rst), .trig(trig), .dist_cm(dist_cm),
    .echo(echo), .busy(busy), .meas_done(meas_done), .err_short(err_short)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int rise; int width; } exp_t;
  exp_t exp_q[$];
  int   err_q[$];
  int   checks = 0;
  int   failures = 0;
  int   jidx = 0;
  int   last_rise = 0;
  int   last_w = 0;

`ifdef ECHO_JITTER_EN
  // Hand-stepped LFSR sequence from seed A5
  int jit_tab [10] = '{165, 74, 149, 42, 84, 169, 83, 167, 78, 157};
`endif

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // n = cycles trig held high; w = expected exact width (0 = expect short reject)
  task automatic do_trig(input int n, input logic [8:0] d, input int w, input bit push);
    int wj;
    dist_cm = d;
    trig = 1'b1;
    repeat (n) @(posedge clk);
    #1 trig = 1'b0;
    if (push) begin
      if (w > 0) begin
        wj = w;
`ifdef ECHO_JITTER_EN
        wj = wj + jit_tab[jidx];
`endif
        jidx++;
        last_rise = cyc + BD + 4;
        last_w = wj;
        exp_q.push_back('{last_rise, wj});
      end else begin
        err_q.push_back(cyc + 3);
      end
    end
  endtask

  task automatic wait_idle(input string name, input int exp_cyc);
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    check(name, cyc, exp_cyc);
  endtask

  task automatic wait_echo(input logic lvl);
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (echo == lvl) break;
    end
    check("wait_echo_level", echo, lvl);
  endtask

  // Monitor: measures every echo pulse and err_short pulse and pops the scoreboard
  bit   in_pulse = 1'b0;
  int   pw = 0;
  int   rise_c = 0;
  exp_t e;
  int   ec;
  bit   fall;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      in_pulse = 1'b0;
      pw = 0;
    end else begin
      fall = in_pulse && !echo;
      if (meas_done || fall) check("meas_done_at_fall", meas_done, fall);
      if (echo) begin
        if (!in_pulse) begin
          in_pulse = 1'b1;
          rise_c = cyc;
          pw = 0;
        end
        pw++;
      end else if (in_pulse) begin
        in_pulse = 1'b0;
        check("echo_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("echo_rise_cycle", rise_c, e.rise);
          check("echo_width", pw, e.width);
        end
      end
      if (err_short) begin
        check("err_short_expected", err_q.size() > 0, 1);
        if (err_q.size() > 0) begin
          ec = err_q.pop_front();
          check("err_short_cycle", cyc, ec);
        end
      end
    end
  end

  initial begin
    #1;
    check("rst_echo", echo, 0);
    check("rst_busy", busy, 0);
    check("rst_meas_done", meas_done, 0);
    check("rst_err_short", err_short, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    do_trig(20, 9'd10, 290, 1'b1);
    wait_idle("busy_fall_d10", last_rise + last_w + HO);

    do_trig(3, 9'd10, 0, 1'b1);
    wait_idle("busy_fall_short", cyc + 3);
    do_trig(8, 9'd10, 0, 1'b1);
    wait_idle("busy_fall_short_edge", cyc + 3);
    do_trig(9, 9'd10, 290, 1'b1);
    wait_idle("busy_fall_min_width", last_rise + last_w + HO);

    do_trig(20, 9'd0, MAXE, 1'b1);
    wait_idle("busy_fall_d0", last_rise + last_w + HO);
    do_trig(20, 9'd45, MAXE, 1'b1);
    wait_idle("busy_fall_d45", last_rise + last_w + HO);
    do_trig(20, 9'd40, 1160, 1'b1);
    wait_idle("busy_fall_d40", last_rise + last_w + HO);

    // Retriggers during ECHO and HOLDOFF are ignored
    do_trig(20, 9'd10, 290, 1'b1);
    wait_echo(1'b1);
    repeat (50) @(posedge clk);
    #1 do_trig(20, 9'd10, 0, 1'b0);
    wait_echo(1'b0);
    repeat (100) @(posedge clk);
    #1 do_trig(20, 9'd10, 0, 1'b0);
    wait_idle("busy_fall_retrig", last_rise + last_w + HO);

    // Trigger held high across the end of HOLDOFF gives no rising edge
    do_trig(20, 9'd2, 58, 1'b1);
    wait_echo(1'b1);
    wait_echo(1'b0);
    repeat (250) @(posedge clk);
    #1 trig = 1'b1;
    wait_idle("busy_fall_stuck", last_rise + last_w + HO);
    repeat (30) @(posedge clk);
    #1 trig = 1'b0;
    repeat (60) @(posedge clk);
    #1 check("stuck_trig_not_accepted", busy, 0);

    do_trig(20, 9'd10, 290, 1'b1);
    wait_idle("busy_fall_after_stuck", last_rise + last_w + HO);

    // dist_cm changes after the latch do not affect the width
    do_trig(20, 9'd10, 290, 1'b1);
    repeat (5) @(posedge clk);
    #1 dist_cm = 9'd30;
    wait_idle("busy_fall_dist_change", last_rise + last_w + HO);

    // Reset mid-echo
    do_trig(20, 9'd10, 290, 1'b1);
    wait_echo(1'b1);
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midreset_echo", echo, 0);
    check("midreset_busy", busy, 0);
    exp_q.delete();
    jidx = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("midreset_meas_done", meas_done, 0);
    repeat (2) @(posedge clk);
    #1 do_trig(20, 9'd2, 58, 1'b1);
    wait_idle("busy_fall_after_reset", last_rise + last_w + HO);

    repeat (20) @(posedge clk);
    #1;
    check("scoreboard_echo_drained", exp_q.size(), 0);
    check("scoreboard_err_drained", err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ultrasonic_echo_responder.md
# ultrasonic_echo_responder

Sensor-side model of the HC-SR04 ultrasonic ranging protocol: it watches the `trig` pulse produced by the ranging controller and answers with an `echo` pulse whose width encodes a programmed distance. It sits opposite the trigger generator and echo counter in closed-loop FPGA self-test and simulation, replacing the physical sensor. It enforces minimum trigger width, burst delay, out-of-range timeout and retrigger hold-off.

## Interface
Parameters:
- `TRIG_MIN_CYC`, 500: minimum valid trigger high time in cycles (10 µs at 50 MHz).
- `BURST_DELAY_CYC`, 25000: gap between accepted trigger fall and echo rise (500 µs).
- `CYC_PER_CM`, 2900: echo cycles per centimetre (58 µs/cm).
- `MAX_CM`, 400: largest in-range distance.
- `MAX_ECHO_CYC`, 1900000: echo width for no-object / out-of-range (38 ms).
- `HOLDOFF_CYC`, 500000: dead time after echo fall before a new trigger is accepted (10 ms).

Ports:
- `clk` in 1: system clock (50 MHz).
- `rst` in 1: asynchronous, active-high reset.
- `trig` in 1: trigger from controller; asynchronous, 2-flop synchronised internally.
- `dist_cm` in 9: simulated distance in cm; sampled once per measurement.
- `echo` out 1: echo pulse to controller (registered).
- `busy` out 1: high in every state except IDLE.
- `meas_done` out 1: one-cycle pulse on the cycle `echo` falls.
- `err_short` out 1: one-cycle pulse when a trigger shorter than `TRIG_MIN_CYC` is rejected.

## Operation
- The FSM has five states: IDLE, TRIG_HI, BURST, ECHO and HOLDOFF.
- `trig_s` is the synchronised trigger. A rising edge is `trig_s` high with the previous sample low.
- **IDLE:**
  - On a rising edge, clear the width counter and go to TRIG_HI.
- **TRIG_HI:**
  - While `trig_s` is 1, increment the width counter. It saturates at `TRIG_MIN_CYC`, so a trigger stuck high never wraps.
  - When `trig_s` is 0 and the count is at least `TRIG_MIN_CYC`, latch `dist_cm`, compute W and go to BURST.
  - When `trig_s` is 0 and the count is below `TRIG_MIN_CYC`, pulse `err_short` and return to IDLE.
- **W computation:**
  - If `dist_cm == 0` or `dist_cm > MAX_CM`, W = `MAX_ECHO_CYC`.
  - Otherwise W = `dist_cm * CYC_PER_CM`, an unsigned 21-bit product. At the defaults the maximum is 400*2900 = 1160000, so it cannot overflow.
- **BURST:** count `BURST_DELAY_CYC` cycles, then go to ECHO.
- **ECHO:** `echo` is 1 for exactly W cycles. Then `echo` goes to 0, `meas_done` pulses, and the FSM goes to HOLDOFF.
- **HOLDOFF:** count `HOLDOFF_CYC` cycles, then go to IDLE.
- Trigger edges in BURST, ECHO and HOLDOFF are ignored. They are not queued and raise no error.
- A trigger still high when HOLDOFF ends produces no rising edge, so it is not accepted.
- Changes to `dist_cm` after the latch have no effect on the current measurement.

## Timing
- **Reset value of every output:** `echo`=0, `busy`=0, `meas_done`=0, `err_short`=0. Reset also forces state IDLE and clears all counters.
- **Reset mid-operation:** any state is abandoned immediately and `echo` drops asynchronously.
- **Trigger synchronisation:** `trig` to `trig_s` takes 2 cycles, so the measured trigger width equals the true width ±1 cycle.
- **t0:** the edge at which TRIG_HI samples `trig_s`=0 with a valid count.
- **Echo position:** `echo` rises on edge t0+`BURST_DELAY_CYC`+1 and falls on edge t0+`BURST_DELAY_CYC`+1+W.
- **`meas_done`:** high for the single cycle that begins at the echo fall edge.
- **Re-acceptance:** `busy` falls `HOLDOFF_CYC` cycles after the echo fall. The earliest accepted rising edge of `trig_s` is the following cycle.
- **`err_short`:** asserted in the cycle after the short trigger's `trig_s` fall is sampled.

## Configuration
- **`ECHO_JITTER_EN` defined:**
  - An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) is added, seeded to 8'hA5 on reset and stepped once per accepted trigger.
  - Its value (0–255) is added to W, including the out-of-range W. This models measurement noise.
- **`ECHO_JITTER_EN` undefined:** no LFSR exists and W is exact.

## Test plan
- **Valid trigger, in range:** `dist_cm`=10, `trig` high 600 cycles → `echo` rises 25001 cycles after t0, stays high exactly 29000 cycles, `meas_done` pulses once, `err_short` stays 0.
- **Short trigger:** `trig` high 100 cycles → `err_short` pulses once, `echo` never rises, `busy` returns to 0.
- **Out of range:** `dist_cm`=0, and separately 450 → `echo` width 1900000 cycles in both cases.
- **Ignored retriggers:** a second 600-cycle trigger during ECHO, and another at HOLDOFF cycle 1000 → no second echo; a trigger after `busy` falls → normal echo.
- **Reset mid-echo:** assert `rst` at echo cycle 5000 → `echo`=0 and `busy`=0 immediately; a following valid trigger with `dist_cm`=2 → 5800-cycle echo.
- **`ECHO_JITTER_EN` build:** three triggers with `dist_cm`=10 → widths 29000+LFSR values matching the golden sequence from seed 8'hA5, each within [29000, 29255].
